// File: rtl/butterfly_result_collector_if.sv
// Byte-serial butterfly result stream in, packed complex-pair words out.
// The collector connects through the slave modport; its environment uses master.
interface butterfly_result_collector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_start;
    logic [4*WIDTH-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;

    modport master (
        output din, din_valid, frame_start, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  din, din_valid, frame_start, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/butterfly_result_collector.sv
// Collects ReY, ImY, ReZ, ImZ bytes of one butterfly into a {ReY,ImY,ReZ,ImZ} word
// and buffers completed words in a first-word-fall-through FIFO.
module butterfly_result_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    butterfly_result_collector_if.slave bus,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clear_err
);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        SLOT_RE_Y,
        SLOT_IM_Y,
        SLOT_RE_Z,
        SLOT_IM_Z
    } slot_t;

    slot_t slot_q;
    slot_t slot_d;

    logic [WIDTH-1:0]   re_y_q;
    logic [WIDTH-1:0]   im_y_q;
    logic [WIDTH-1:0]   re_z_q;
    logic [4*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FILL_W-1:0]  fill_q;

    logic store_re_y;
    logic store_im_y;
    logic store_re_z;
    logic frame_done;
    logic resync;
    logic pop;
    logic push;
    logic drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_RE_Y;
        end else begin
            slot_q <= slot_d;
        end
    end

    // A frame_start always restarts assembly at ReY; a partial frame it cuts short is lost.
    always_comb begin
        slot_d     = slot_q;
        store_re_y = 1'b0;
        store_im_y = 1'b0;
        store_re_z = 1'b0;
        frame_done = 1'b0;
        resync     = 1'b0;
        if (bus.din_valid) begin
            if (bus.frame_start) begin
                store_re_y = 1'b1;
                resync     = (slot_q != SLOT_RE_Y);
                slot_d     = SLOT_IM_Y;
            end else begin
                case (slot_q)
                    SLOT_RE_Y: begin
                        store_re_y = 1'b1;
                        slot_d     = SLOT_IM_Y;
                    end
                    SLOT_IM_Y: begin
                        store_im_y = 1'b1;
                        slot_d     = SLOT_RE_Z;
                    end
                    SLOT_RE_Z: begin
                        store_re_z = 1'b1;
                        slot_d     = SLOT_IM_Z;
                    end
                    default: begin
                        frame_done = 1'b1;
                        slot_d     = SLOT_RE_Y;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_y_q <= '0;
            im_y_q <= '0;
            re_z_q <= '0;
        end else begin
            if (store_re_y) re_y_q <= bus.din;
            if (store_im_y) im_y_q <= bus.din;
            if (store_re_z) re_z_q <= bus.din;
        end
    end

    // A full FIFO still takes a word when the head leaves on the same edge.
    always_comb begin
        pop  = bus.dout_valid && bus.dout_ready;
        push = frame_done && ((fill_q != FULL_LEVEL) || pop);
        drop = frame_done && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {re_y_q, im_y_q, re_z_q, bus.din};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (resync) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign bus.dout_valid = (fill_q != '0);
    assign bus.dout       = bus.dout_valid ? mem[rd_ptr] : '0;
    assign fill           = fill_q;
endmodule

// File: tb/tb_butterfly_result_collector.sv
// Directed and randomized bench for butterfly_result_collector, checked against a
// queue-based model of frame assembly and the word FIFO.
module tb_butterfly_result_collector;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] fill;
    logic       overflow;
    logic       frame_err;
    logic       clear_err;

    int total;
    int bad;

    logic [7:0]  cur_bytes[$];
    logic [31:0] words[$];
    bit          m_ovf;
    bit          m_ferr;

    butterfly_result_collector_if #(.WIDTH(WIDTH)) bus ();

    butterfly_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fill      (fill),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clear_err (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Model of one clock edge, from the byte/frame/FIFO rules rather than slot encoding.
    task automatic model_update(input logic r, input logic v, input logic fs,
                                input logic [7:0] d, input logic rdy, input logic clr);
        bit          complete;
        bit          ovf_evt;
        bit          ferr_evt;
        bit          do_pop;
        logic [31:0] w;
        complete = 0;
        ovf_evt  = 0;
        ferr_evt = 0;
        w        = '0;
        if (r) begin
            cur_bytes.delete();
            words.delete();
            m_ovf  = 0;
            m_ferr = 0;
            return;
        end
        do_pop = (words.size() != 0) && rdy;
        if (v) begin
            if (fs) begin
                if (cur_bytes.size() != 0) ferr_evt = 1;
                cur_bytes.delete();
            end
            cur_bytes.push_back(d);
            if (cur_bytes.size() == 4) begin
                w = {cur_bytes[0], cur_bytes[1], cur_bytes[2], cur_bytes[3]};
                cur_bytes.delete();
                complete = 1;
            end
        end
        if (do_pop) void'(words.pop_front());
        if (complete) begin
            if (words.size() < DEPTH) words.push_back(w);
            else ovf_evt = 1;
        end
        if (ovf_evt) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (ferr_evt) m_ferr = 1;
        else if (clr) m_ferr = 0;
    endtask

    task automatic check_output();
        logic [31:0] exp_dout;
        exp_dout = (words.size() != 0) ? words[0] : 32'h0;
        check_val("dout", bus.dout, exp_dout);
        check_val("dout_valid", {31'b0, bus.dout_valid}, {31'b0, words.size() != 0});
        check_val("fill", {29'b0, fill}, words.size());
        check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check_val("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
    endtask

    // Drive one cycle at the falling edge, model the rising edge, check at the next falling edge.
    task automatic apply_stimulus(input logic r, input logic v, input logic fs,
                                  input logic [7:0] d, input logic rdy, input logic clr);
        rst             = r;
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din         = d;
        bus.dout_ready  = rdy;
        clear_err       = clr;
        @(posedge clk);
        model_update(r, v, fs, d, rdy, clr);
        @(negedge clk);
        check_output();
    endtask

    task automatic send_word(input logic [31:0] w, input logic fs,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, fs && (i == 0), w[31-8*i -: 8],
                           (i == 3) ? rdy_last : 1'b0, (i == 3) ? clr_last : 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst             = 1'b1;
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.dout_ready  = 1'b0;
        clear_err       = 1'b0;
        @(negedge clk);

        apply_stimulus(1, 0, 0, 8'h00, 0, 0);
        apply_stimulus(1, 0, 0, 8'h00, 0, 0);
        check_val("reset_fill", {29'b0, fill}, 32'd0);
        check_val("reset_dout", bus.dout, 32'h0);

        // Single frame lands one cycle after its last byte.
        send_word(32'h10203040, 1, 0, 0);
        check_val("t1_dout", bus.dout, 32'h10203040);
        check_val("t1_fill", {29'b0, fill}, 32'd1);
        check_val("t1_flags", {30'b0, overflow, frame_err}, 32'd0);
        apply_stimulus(0, 0, 0, 8'h00, 1, 0);

        // Five frames into a four-deep FIFO, then a sixth with clear_err on its drop edge.
        for (int k = 0; k < 5; k++) begin
            send_word(32'hA0A1A2A3 + k * 32'h10101010, 1, 0, 0);
        end
        check_val("t2_fill", {29'b0, fill}, 32'd4);
        check_val("t2_ovf", {31'b0, overflow}, 32'd1);
        send_word(32'hF0F1F2F3, 1, 0, 1);
        check_val("t6_ovf_wins", {31'b0, overflow}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_val("t2_order", bus.dout, 32'hA0A1A2A3 + k * 32'h10101010);
            apply_stimulus(0, 0, 0, 8'h00, 1, 0);
        end
        check_val("t2_empty", {31'b0, bus.dout_valid}, 32'd0);
        apply_stimulus(0, 0, 0, 8'h00, 0, 1);
        check_val("t6_clear", {30'b0, overflow, frame_err}, 32'd0);

        // Full FIFO: last byte of a fifth frame coincides with a pop.
        for (int k = 0; k < 4; k++) begin
            send_word(32'h01020304 + k * 32'h01010101, 1, 0, 0);
        end
        send_word(32'h55667788, 1, 1, 0);
        check_val("t3_fill", {29'b0, fill}, 32'd4);
        check_val("t3_ovf", {31'b0, overflow}, 32'd0);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 0, 8'h00, 1, 0);
        check_val("t3_last", bus.dout, 32'h55667788);
        apply_stimulus(0, 0, 0, 8'h00, 1, 0);

        // Frame restart mid-frame.
        apply_stimulus(0, 1, 1, 8'h11, 0, 0);
        apply_stimulus(0, 1, 0, 8'h22, 0, 0);
        send_word(32'hA1A2A3A4, 1, 0, 0);
        check_val("t4_ferr", {31'b0, frame_err}, 32'd1);
        check_val("t4_fill", {29'b0, fill}, 32'd1);
        check_val("t4_dout", bus.dout, 32'hA1A2A3A4);

        // Reset with two words held and a partial frame in progress.
        send_word(32'hC1C2C3C4, 1, 0, 0);
        apply_stimulus(0, 1, 1, 8'h77, 0, 0);
        apply_stimulus(0, 1, 0, 8'h88, 0, 0);
        apply_stimulus(1, 0, 0, 8'h00, 0, 0);
        check_val("t5_fill", {29'b0, fill}, 32'd0);
        check_val("t5_valid", {31'b0, bus.dout_valid}, 32'd0);
        check_val("t5_flags", {30'b0, overflow, frame_err}, 32'd0);
        send_word(32'h0A0B0C0D, 0, 0, 0);
        check_val("t5_fresh", bus.dout, 32'h0A0B0C0D);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            apply_stimulus($urandom_range(0, 149) == 0,
                           $urandom_range(0, 99) < 70,
                           $urandom_range(0, 99) < 15,
                           8'($urandom),
                           $urandom_range(0, 99) < 40,
                           $urandom_range(0, 99) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
